// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// -----------------------------------------------------------------------------
// Synchronous FIFO controller in front of the 8x4 single-clock RAM. It turns a
// push/pop stream into RAM write/read strobes and addresses, tracks how many
// words are stored, and returns popped data one cycle after the pop with a
// valid tag. The RAM registers its read data, so pop_data is a pass-through.
//
// Ports:
//   clk            rising-edge system clock
//   rst_n          asynchronous active-low reset
//   push/push_data enqueue request and its data
//   pop            dequeue request
//   full/empty     occupancy flags (combinational from the word count)
//   pop_data       dequeued word, meaningful while pop_valid=1
//   pop_valid      registered: a pop was accepted on the previous edge
//   overflow       one-cycle pulse after a rejected push
//   underflow      one-cycle pulse after a rejected pop
//   ram_write_*    RAM write port drive (enable, 8-bit address, data)
//   ram_read_*     RAM read port drive (enable, 8-bit address) and read data
//
// Optional feature (macro RAM_FIFO_CTRL_LEVEL_EN):
//   parameter AF_THRESH, output level (= count), registered almost_full
//   (next count >= AF_THRESH) and almost_empty (next count <= 1).
// -----------------------------------------------------------------------------
module ram_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 4
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    ,
    parameter int AF_THRESH = DEPTH - 2
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] pop_data,
    output logic          pop_valid,
    output logic          overflow,
    output logic          underflow,
    output logic          ram_write_en,
    output logic [7:0]    ram_write_addr,
    output logic [DW-1:0] ram_write_data,
    output logic          ram_read_en,
    output logic [7:0]    ram_read_addr,
    input  logic [DW-1:0] ram_read_data
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [AW:0]   level,
    output logic          almost_full,
    output logic          almost_empty
`endif
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push_acc;
    logic          pop_acc;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Accept decisions use the current flags, so a push+pop at full only
    // pops and a push+pop at empty only pushes (no bypass path).
    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    assign ram_write_en   = push_acc;
    assign ram_write_addr = 8'(wr_ptr);
    assign ram_write_data = push_data;
    assign ram_read_en    = pop_acc;
    assign ram_read_addr  = 8'(rd_ptr);

    assign pop_data = ram_read_data;

    always_comb begin
        count_next = count;
        case ({push_acc, pop_acc})
            2'b10:   count_next = count + COUNT_ONE;
            2'b01:   count_next = count - COUNT_ONE;
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two equal to 2**AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count     <= count_next;
            pop_valid <= pop_acc;
            overflow  <= push & full;
            underflow <= pop & empty;
        end
    end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
    localparam logic [AW:0] AF_LEVEL = (AW + 1)'(AF_THRESH);

    assign level = count;

    // Registered from the next count so the flags line up with level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= AF_LEVEL);
            almost_empty <= (count_next <= COUNT_ONE);
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// -----------------------------------------------------------------------------
// Self-checking bench for ram_fifo_ctrl. A small 8x4 RAM with registered read
// data sits on the controller's RAM port. Expected values come from a queue
// model: occupancy is the queue size, addresses are the running push/pop
// totals modulo the depth, popped data is the queue head.
// -----------------------------------------------------------------------------
module tb_ram_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 4;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic          full;
    logic          empty;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          overflow;
    logic          underflow;
    logic          ram_write_en;
    logic [7:0]    ram_write_addr;
    logic [DW-1:0] ram_write_data;
    logic          ram_read_en;
    logic [7:0]    ram_read_addr;
    logic [DW-1:0] ram_read_data;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;
`endif

    ram_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push           (push),
        .push_data      (push_data),
        .pop            (pop),
        .full           (full),
        .empty          (empty),
        .pop_data       (pop_data),
        .pop_valid      (pop_valid),
        .overflow       (overflow),
        .underflow      (underflow),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_en    (ram_read_en),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
`ifdef RAM_FIFO_CTRL_LEVEL_EN
        ,
        .level          (level),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 8x4 RAM with registered read data.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) begin
            mem[ram_write_addr[AW-1:0]] <= ram_write_data;
        end
        if (ram_read_en) begin
            ram_read_data <= mem[ram_read_addr[AW-1:0]];
        end
    end

    // Reference model state.
    logic [DW-1:0] model_q[$];
    int            n_pushed;
    int            n_popped;
    logic          exp_pv;
    logic [DW-1:0] exp_pd;
    logic          exp_ovf;
    logic          exp_udf;

    int errors;
    int checks;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic reset_model();
        model_q.delete();
        n_pushed = 0;
        n_popped = 0;
        exp_pv   = 1'b0;
        exp_pd   = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        int cnt;
        cnt = model_q.size();
        check_output({tag, ".full"},      32'(full),      32'(cnt == DEPTH));
        check_output({tag, ".empty"},     32'(empty),     32'(cnt == 0));
        check_output({tag, ".pop_valid"}, 32'(pop_valid), 32'(exp_pv));
        if (exp_pv) begin
            check_output({tag, ".pop_data"}, 32'(pop_data), 32'(exp_pd));
        end
        check_output({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
        check_output({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
`ifdef RAM_FIFO_CTRL_LEVEL_EN
        check_output({tag, ".level"},        32'(level),        32'(cnt));
        check_output({tag, ".almost_full"},  32'(almost_full),  32'(cnt >= DEPTH - 2));
        check_output({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 1));
`endif
    endtask

    // One clock cycle: drive inputs just after a rising edge, check all
    // outputs on the falling edge, then advance the model across the edge.
    task automatic apply_stimulus(input logic p, input logic [DW-1:0] d, input logic o,
                                  input string tag);
        logic is_full;
        logic is_empty;
        logic p_acc;
        logic o_acc;
        push      = p;
        push_data = d;
        pop       = o;
        @(negedge clk);
        is_full  = (model_q.size() == DEPTH);
        is_empty = (model_q.size() == 0);
        p_acc    = p && !is_full;
        o_acc    = o && !is_empty;
        check_state(tag);
        check_output({tag, ".wr_en"},   32'(ram_write_en),   32'(p_acc));
        check_output({tag, ".wr_addr"}, 32'(ram_write_addr), 32'(n_pushed % DEPTH));
        check_output({tag, ".rd_en"},   32'(ram_read_en),    32'(o_acc));
        check_output({tag, ".rd_addr"}, 32'(ram_read_addr),  32'(n_popped % DEPTH));
        if (p_acc) begin
            check_output({tag, ".wr_data"}, 32'(ram_write_data), 32'(d));
        end
        if (o_acc) begin
            exp_pd = model_q.pop_front();
            n_popped++;
        end
        if (p_acc) begin
            model_q.push_back(d);
            n_pushed++;
        end
        exp_pv  = o_acc;
        exp_ovf = p && is_full;
        exp_udf = o && is_empty;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        push      = 1'b0;
        push_data = '0;
        pop       = 1'b0;
        reset_model();

        // Reset and idle.
        #12;
        check_state("reset");
        check_output("reset.wr_en", 32'(ram_write_en), 32'(0));
        check_output("reset.rd_en", 32'(ram_read_en),  32'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) apply_stimulus(1'b0, '0, 1'b0, "idle");

        // Fill with 0x1..0x8, then one rejected push.
        for (int i = 1; i <= DEPTH; i++) apply_stimulus(1'b1, DW'(i), 1'b0, "fill");
        check_output("fill.full_after_8", 32'(full), 32'(1));
        apply_stimulus(1'b1, 4'hF, 1'b0, "push_at_full");
        check_output("overflow_pulse", 32'(overflow), 32'(1));
        apply_stimulus(1'b0, '0, 1'b0, "after_overflow");

        // Drain back-to-back, then a rejected pop.
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, '0, 1'b1, "drain");
        apply_stimulus(1'b0, '0, 1'b1, "pop_at_empty");
        check_output("underflow_pulse", 32'(underflow), 32'(1));
        apply_stimulus(1'b0, '0, 1'b0, "after_underflow");

        // Pointer wrap: push 5, pop 5, then push 0xA..0xE and pop them.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, DW'(i), 1'b0, "wrap_push5");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, '0, 1'b1, "wrap_pop5");
        for (int i = 10; i <= 14; i++) apply_stimulus(1'b1, DW'(i), 1'b0, "wrap_push");
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, '0, 1'b1, "wrap_pop");

        // Simultaneous push+pop with 3 stored, then at full and at empty.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, DW'(i + 3), 1'b0, "sim_pre");
        for (int i = 0; i < 10; i++)
            apply_stimulus(1'b1, DW'($urandom_range(0, 15)), 1'b1, "sim_both");
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, DW'(i + 7), 1'b0, "sim_fill");
        apply_stimulus(1'b1, 4'h9, 1'b1, "both_at_full");
        apply_stimulus(1'b0, '0, 1'b0, "after_both_full");
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, '0, 1'b1, "sim_drain");
        apply_stimulus(1'b0, '0, 1'b0, "sim_settle");
        apply_stimulus(1'b1, 4'h6, 1'b1, "both_at_empty");
        check_output("both_at_empty.underflow", 32'(underflow), 32'(1));
        apply_stimulus(1'b0, '0, 1'b1, "drain_last");
        apply_stimulus(1'b0, '0, 1'b0, "idle2");

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            apply_stimulus(1'($urandom_range(0, 1)), DW'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), "random");

        // Reset mid-burst: 4 words stored and a pop in flight.
        apply_stimulus(1'b0, '0, 1'b1, "pre_reset_drain");
        while (model_q.size() != 0) apply_stimulus(1'b0, '0, 1'b1, "pre_reset_drain");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, DW'(i + 1), 1'b0, "pre_reset_fill");
        apply_stimulus(1'b0, '0, 1'b1, "pop_in_flight");
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        #1;
        reset_model();
        check_output("midreset.empty",     32'(empty),     32'(1));
        check_output("midreset.pop_valid", 32'(pop_valid), 32'(0));
        check_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 4'hC, 1'b0, "post_reset_push");
        apply_stimulus(1'b0, '0, 1'b1, "post_reset_pop");
        apply_stimulus(1'b0, '0, 1'b0, "post_reset_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
